// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// behind a start/busy/done handshake. Results hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // New difference bit enters at the MSB so after WIDTH steps bit 0 is the LSB.
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = d_bit;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nxt;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = res_shift;
                    bout_d  = br_nxt;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8 (directed), 1 and 16 (random).
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       s8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       s1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;
    logic        s16, bin16, busy16, done16, bout16;
    logic [15:0] a16, b16, diff16;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));
    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16));

    int n_checks = 0;
    int n_fail   = 0;
    int dones8 = 0, dones1 = 0, dones16 = 0;
    int starts1 = 0, starts16 = 0;

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [16:0] q16[$];
    logic [8:0]  e8;
    logic [1:0]  e1;
    logic [16:0] e16;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {borrow, diff} from wide unsigned arithmetic.
    function automatic logic [64:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic bi);
        logic [63:0] mask;
        logic [64:0] r;
        mask     = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        r[63:0]  = (a - b - 64'(bi)) & mask;
        r[64]    = ({1'b0, a} < ({1'b0, b} + 65'(bi)));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done8) begin
            dones8++;
            if (q8.size() == 0) check_eq("sb8_spurious_done", 64'd1, 64'd0);
            else begin
                e8 = q8.pop_front();
                check_eq("sb8_result", 64'({bout8, diff8}), 64'(e8));
            end
        end
        if (done1) begin
            dones1++;
            if (q1.size() == 0) check_eq("sb1_spurious_done", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                check_eq("sb1_result", 64'({bout1, diff1}), 64'(e1));
            end
        end
        if (done16) begin
            dones16++;
            if (q16.size() == 0) check_eq("sb16_spurious_done", 64'd1, 64'd0);
            else begin
                e16 = q16.pop_front();
                check_eq("sb16_result", 64'({bout16, diff16}), 64'(e16));
            end
        end
    end

    task automatic finish8(output int lat);
        lat = 0;
        while (busy8 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [64:0] m;
        int lat;
        m = model(8, 64'(a), 64'(b), bi);
        s8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
        q8.push_back({m[64], m[7:0]});
        tick();
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        check_eq("busy_after_start", 64'(busy8), 64'd1);
        finish8(lat);
        check_eq("latency8", 64'(lat), 64'd8);
        check_eq("done_at_latency", 64'(done8), 64'd1);
        check_eq("diff8", 64'(diff8), 64'(m[7:0]));
        check_eq("bout8", 64'(bout8), 64'(m[64]));
        tick();
        check_eq("done_one_cycle", 64'(done8), 64'd0);
    endtask

    task automatic rand1();
        logic [64:0] m;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            m = model(1, 64'(a1), 64'(b1), bin1);
            q1.push_back({m[64], m[0]});
            starts1++;
            s1 = 1'b1;
            tick();
            s1 = 1'b0;
            lat = 0;
            while (busy1 && lat < 10) begin
                tick();
                lat++;
            end
            check_eq("w1_latency", 64'(lat), 64'd1);
        end
    endtask

    task automatic rand16();
        logic [64:0] m;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
            if (n % 50 == 0) b16 = a16;
            m = model(16, 64'(a16), 64'(b16), bin16);
            q16.push_back({m[64], m[15:0]});
            starts16++;
            s16 = 1'b1;
            tick();
            s16 = 1'b0;
            lat = 0;
            while (busy16 && lat < 40) begin
                tick();
                lat++;
            end
            check_eq("w16_latency", 64'(lat), 64'd16);
        end
    endtask

    initial begin
        logic [64:0] m;
        int lat;
        int nd;

        rst_n = 1'b0;
        s8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        s1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        s16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        tick();
        tick();
        check_eq("rst_busy", 64'(busy8), 64'd0);
        check_eq("rst_done", 64'(done8), 64'd0);
        check_eq("rst_diff", 64'(diff8), 64'd0);
        check_eq("rst_bout", 64'(bout8), 64'd0);
        check_eq("rst_diff16", 64'(diff16), 64'd0);
        rst_n = 1'b1;
        tick();

        run8(8'h5A, 8'h23, 1'b0);
        check_eq("basic_diff_0x37", 64'(diff8), 64'h37);
        run8(8'h00, 8'h01, 1'b0);
        check_eq("underflow_diff", 64'(diff8), 64'hFF);
        check_eq("underflow_bout", 64'(bout8), 64'd1);
        run8(8'h10, 8'h10, 1'b1);
        check_eq("eq_bin_diff", 64'(diff8), 64'hFF);
        check_eq("eq_bin_bout", 64'(bout8), 64'd1);
        run8(8'hFF, 8'h00, 1'b1);
        check_eq("max_bin_diff", 64'(diff8), 64'hFE);
        check_eq("max_bin_bout", 64'(bout8), 64'd0);

        // start held high and operands changed while shifting
        m = model(8, 64'h5A, 64'h23, 1'b0);
        s8 = 1'b1; a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0;
        q8.push_back({m[64], m[7:0]});
        tick();
        a8 = 8'hAA; b8 = 8'h55;
        lat = 0;
        while (busy8 && lat < 40) begin
            if (lat == 6) s8 = 1'b0;
            tick();
            lat++;
        end
        check_eq("hold_latency", 64'(lat), 64'd8);
        check_eq("hold_done", 64'(done8), 64'd1);
        check_eq("hold_diff", 64'(diff8), 64'h37);
        check_eq("hold_bout", 64'(bout8), 64'd0);
        tick();
        check_eq("hold_done_low", 64'(done8), 64'd0);
        check_eq("hold_no_restart", 64'(busy8), 64'd0);

        // back-to-back start in the DONE cycle
        m = model(8, 64'h5A, 64'h23, 1'b0);
        s8 = 1'b1; a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0;
        q8.push_back({m[64], m[7:0]});
        tick();
        s8 = 1'b0;
        finish8(lat);
        check_eq("b2b_first_done", 64'(done8), 64'd1);
        m = model(8, 64'h80, 64'h01, 1'b0);
        s8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        q8.push_back({m[64], m[7:0]});
        tick();
        s8 = 1'b0;
        check_eq("b2b_no_bubble", 64'(busy8), 64'd1);
        check_eq("b2b_first_held", 64'(diff8), 64'h37);
        finish8(lat);
        check_eq("b2b_latency", 64'(lat), 64'd8);
        check_eq("b2b_done", 64'(done8), 64'd1);
        check_eq("b2b_diff", 64'(diff8), 64'h7F);
        check_eq("b2b_bout", 64'(bout8), 64'd0);
        tick();

        // reset at bit 4 aborts the operation
        s8 = 1'b1; a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b0;
        tick();
        s8 = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("abort_busy", 64'(busy8), 64'd0);
        check_eq("abort_done", 64'(done8), 64'd0);
        check_eq("abort_diff", 64'(diff8), 64'd0);
        check_eq("abort_bout", 64'(bout8), 64'd0);
        nd = 0;
        repeat (12) begin
            tick();
            if (done8) nd++;
        end
        check_eq("abort_no_done", 64'(nd), 64'd0);
        run8(8'h33, 8'h44, 1'b1);

        fork
            rand1();
            rand16();
        join
        repeat (4) tick();
        check_eq("w1_done_count", 64'(dones1), 64'(starts1));
        check_eq("w16_done_count", 64'(dones16), 64'(starts16));
        check_eq("w8_queue_empty", 64'(q8.size()), 64'd0);
        check_eq("w1_queue_empty", 64'(q1.size()), 64'd0);
        check_eq("w16_queue_empty", 64'(q16.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
